bpsk_tx_scheduler: RTL and testbench

- Sits in front of packet_serializer and signal_modulator.
- Shares the single BPSK transmit path between NUM_REQ packet sources using round-robin arbitration.
- Latches the granted packet, loads the serializer, gates the modulator for exactly PACKET_SIZE bits, then enforces an inter-packet gap.
- Flags a stalled modulator through a bit-strobe watchdog.

---
 rtl/bpsk_tx_scheduler_if.sv | 31 +++
 rtl/bpsk_tx_scheduler.sv | 138 +++++++++++++
 tb/tb_bpsk_tx_scheduler.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bpsk_tx_scheduler_if.sv
// Signal bundle between the packet sources/modulator side and bpsk_tx_scheduler.
// The scheduler uses the slave modport; whoever drives the sources and strobes uses master.
interface bpsk_tx_scheduler_if #(
  parameter int PACKET_SIZE = 192,
  parameter int NUM_REQ     = 4
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ*PACKET_SIZE-1:0] req_packet;
  logic                           abort;
  logic                           bit_next;
  logic [NUM_REQ-1:0]             grant;
  logic [PACKET_SIZE-1:0]         packet_out;
  logic                           ser_load;
  logic                           mod_enable;
  logic                           busy;
  logic [ID_W-1:0]                active_id;
  logic [15:0]                    packets_sent;
  logic                           timeout_err;

  modport master (
    output req, req_packet, abort, bit_next,
    input  grant, packet_out, ser_load, mod_enable, busy, active_id, packets_sent, timeout_err
  );

  modport slave (
    input  req, req_packet, abort, bit_next,
    output grant, packet_out, ser_load, mod_enable, busy, active_id, packets_sent, timeout_err
  );
endinterface

// File: rtl/bpsk_tx_scheduler.sv
// Round-robin scheduler sharing one BPSK transmit path among NUM_REQ packet sources:
// latches the winner, loads the serializer, gates the modulator per bit, then idles a gap.
//
// state | meaning
// IDLE  | no packet in flight; arbitrates among pending requests
// LOAD  | winner latched; serializer load pulse follows
// SEND  | modulator enabled; counting bit_next strobes, watchdog running
// GAP   | mandatory idle time before the next arbitration
module bpsk_tx_scheduler #(
  parameter int PACKET_SIZE = 192,
  parameter int NUM_REQ     = 4,
  parameter int GAP_CYCLES  = 16,
  parameter int TIMEOUT     = 4096
) (
  input  logic               clock,
  input  logic               reset_n,
  bpsk_tx_scheduler_if.slave bus
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BIT_W = (PACKET_SIZE > 1) ? $clog2(PACKET_SIZE) : 1;
  localparam int WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PACKET_SIZE - 1);
  localparam logic [WD_W-1:0]  WD_LOAD  = WD_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_t;

  state_t                 state, next_state;
  logic [ID_W-1:0]        last;
  logic [ID_W-1:0]        cand;
  logic [ID_W-1:0]        pick;
  logic                   pick_valid;
  logic [PACKET_SIZE-1:0] pkt_sel;
  logic [BIT_W-1:0]       bit_cnt;
  logic [WD_W-1:0]        wdog_cnt;
  logic [GAP_W-1:0]       gap_cnt;
  logic                   strobe, idle_tick, finish_ok, wd_fire, send_exit;
  logic [NUM_REQ-1:0]     grant_d;
  logic                   ser_load_d, mod_enable_d, busy_d;

  // Scan starts one past the last winner so a held request waits for all others.
  always_comb begin
    cand       = last;
    pick       = '0;
    pick_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (cand == ID_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
      if (!pick_valid && bus.req[cand]) begin
        pick       = cand;
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    pkt_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == ID_W'(i)) pkt_sel = bus.req_packet[i*PACKET_SIZE +: PACKET_SIZE];
    end
  end

  // The first SEND cycle has the modulator still disabled, so strobes only count once enabled.
  assign strobe    = (state == S_SEND) && bus.mod_enable && bus.bit_next;
  assign idle_tick = (state == S_SEND) && bus.mod_enable && !bus.bit_next;
  assign finish_ok = strobe && (bit_cnt == '0);
  assign wd_fire   = idle_tick && (wdog_cnt == WD_W'(1));
  assign send_exit = finish_ok || ((state == S_SEND) && bus.abort) || wd_fire;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:  if (pick_valid) next_state = S_LOAD;
      S_LOAD:  next_state = S_SEND;
      S_SEND:  if (send_exit) next_state = S_GAP;
      S_GAP:   if (gap_cnt == '0) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    grant_d = '0;
    if ((state == S_IDLE) && pick_valid) grant_d[pick] = 1'b1;
    ser_load_d   = (state == S_LOAD);
    mod_enable_d = (state == S_SEND) && (next_state == S_SEND);
    busy_d       = (next_state != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.grant        <= '0;
      bus.packet_out   <= '0;
      bus.ser_load     <= 1'b0;
      bus.mod_enable   <= 1'b0;
      bus.busy         <= 1'b0;
      bus.active_id    <= '0;
      bus.packets_sent <= '0;
      bus.timeout_err  <= 1'b0;
      last             <= ID_W'(NUM_REQ - 1);
      bit_cnt          <= '0;
      wdog_cnt         <= '0;
      gap_cnt          <= '0;
    end else begin
      bus.grant      <= grant_d;
      bus.ser_load   <= ser_load_d;
      bus.mod_enable <= mod_enable_d;
      bus.busy       <= busy_d;

      if ((state == S_IDLE) && pick_valid) begin
        bus.packet_out <= pkt_sel;
        bus.active_id  <= pick;
        last           <= pick;
      end

      // Both counters run down; bit_cnt holds bits remaining after the current one.
      if (state == S_LOAD) begin
        bit_cnt  <= BIT_LAST;
        wdog_cnt <= WD_LOAD;
      end else if (strobe) begin
        if (bit_cnt != '0) bit_cnt <= bit_cnt - 1'b1;
        wdog_cnt <= WD_LOAD;
      end else if (idle_tick) begin
        wdog_cnt <= wdog_cnt - 1'b1;
      end

      if (finish_ok) bus.packets_sent <= bus.packets_sent + 16'd1;
      if (wd_fire)   bus.timeout_err  <= 1'b1;

      if ((state == S_SEND) && send_exit)         gap_cnt <= GAP_LOAD;
      else if ((state == S_GAP) && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_bpsk_tx_scheduler.sv
// Randomized bench for bpsk_tx_scheduler against a transaction-level round-robin model.
// Two instances (GAP_CYCLES=16 and 0) share stimulus; sel routes traffic to one at a time.
module tb_bpsk_tx_scheduler;
  localparam int PS    = 192;
  localparam int NR    = 4;
  localparam int TO    = 64;
  localparam int GAP_A = 16;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic           sel = 1'b0;
  logic [NR-1:0]  req = '0;
  logic [NR*PS-1:0] req_packet = '0;
  logic           abort = 1'b0;
  logic           bit_next = 1'b0;

  logic [NR-1:0]  grant;
  logic [PS-1:0]  packet_out;
  logic           ser_load, mod_enable, busy, timeout_err;
  logic [1:0]     active_id;
  logic [15:0]    packets_sent;

  int n_checks = 0;
  int n_fail   = 0;
  int m_last, m_sent, gap_eff, hold_mode;
  logic m_err;

  bpsk_tx_scheduler_if #(.PACKET_SIZE(PS), .NUM_REQ(NR)) bus_a ();
  bpsk_tx_scheduler_if #(.PACKET_SIZE(PS), .NUM_REQ(NR)) bus_z ();

  assign bus_a.req        = sel ? '0 : req;
  assign bus_a.req_packet = req_packet;
  assign bus_a.abort      = sel ? 1'b0 : abort;
  assign bus_a.bit_next   = sel ? 1'b0 : bit_next;
  assign bus_z.req        = sel ? req : '0;
  assign bus_z.req_packet = req_packet;
  assign bus_z.abort      = sel ? abort : 1'b0;
  assign bus_z.bit_next   = sel ? bit_next : 1'b0;

  assign grant        = sel ? bus_z.grant        : bus_a.grant;
  assign packet_out   = sel ? bus_z.packet_out   : bus_a.packet_out;
  assign ser_load     = sel ? bus_z.ser_load     : bus_a.ser_load;
  assign mod_enable   = sel ? bus_z.mod_enable   : bus_a.mod_enable;
  assign busy         = sel ? bus_z.busy         : bus_a.busy;
  assign active_id    = sel ? bus_z.active_id    : bus_a.active_id;
  assign packets_sent = sel ? bus_z.packets_sent : bus_a.packets_sent;
  assign timeout_err  = sel ? bus_z.timeout_err  : bus_a.timeout_err;

  bpsk_tx_scheduler #(.PACKET_SIZE(PS), .NUM_REQ(NR), .GAP_CYCLES(GAP_A), .TIMEOUT(TO)) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(bus_a)
  );
  bpsk_tx_scheduler #(.PACKET_SIZE(PS), .NUM_REQ(NR), .GAP_CYCLES(0), .TIMEOUT(TO)) dut_z (
    .clock(clock), .reset_n(reset_n), .bus(bus_z)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [PS-1:0] got, input logic [PS-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  function automatic logic [PS-1:0] rand_pkt();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference arbitration: first requester after the previous winner, wrapping.
  function automatic int rr_pick(input logic [NR-1:0] r, input int prev);
    for (int i = 1; i <= NR; i++) if (r[(prev + i) % NR]) return (prev + i) % NR;
    return -1;
  endfunction

  task automatic model_reset();
    m_last = NR - 1;
    m_sent = 0;
    m_err  = 1'b0;
  endtask

  task automatic do_reset();
    req = '0; abort = 1'b0; bit_next = 1'b0;
    tick();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic add_reqs();
    logic [NR-1:0] nw;
    nw = NR'($urandom_range(0, (1 << NR) - 1)) & ~req;
    for (int i = 0; i < NR; i++) if (nw[i]) req_packet[i*PS +: PS] = rand_pkt();
    req = req | nw;
  endtask

  task automatic ensure_req();
    int s;
    add_reqs();
    if (req == '0) begin
      s = $urandom_range(0, NR - 1);
      req_packet[s*PS +: PS] = rand_pkt();
      req[s] = 1'b1;
    end
  endtask

  // Called at a negedge while the DUT sits in IDLE with req already set up.
  // mode: 0 complete, 1 abort after nbits, 2 stall after nbits, 3 reset after nbits,
  //       4 complete with abort on the final strobe.
  task automatic serve(input int mode, input int nbits, input int minsp, input int maxsp);
    int k, j, nb, seen_en;
    logic [NR-1:0] exp_grant;
    logic [PS-1:0] exp_pkt;
    k = rr_pick(req, m_last);
    exp_grant = '0;
    if (k >= 0) exp_grant[k] = 1'b1;
    exp_pkt = (k >= 0) ? req_packet[k*PS +: PS] : '0;
    tick();
    check("grant", PS'(grant), PS'(exp_grant));
    check("active_id", PS'(active_id), PS'(k));
    check("packet_out", packet_out, exp_pkt);
    m_last = k;
    if (hold_mode == 0 || (hold_mode == 1 && $urandom_range(0, 3) != 0)) req[k] = 1'b0;
    tick();
    check("ser_load", PS'(ser_load), PS'(1));
    check("mod_en_early", PS'(mod_enable), PS'(0));
    tick();
    check("mod_en_start", PS'(mod_enable), PS'(1));
    if (hold_mode == 1) add_reqs();

    nb = (mode == 0 || mode == 4) ? PS : nbits;
    seen_en = 0;
    for (int b = 0; b < nb; b++) begin
      repeat ($urandom_range(minsp, maxsp)) tick();
      if (mod_enable) seen_en++;
      bit_next = 1'b1;
      if (mode == 4 && b == nb - 1) abort = 1'b1;
      tick();
      bit_next = 1'b0;
      abort = 1'b0;
    end
    check("strobes_enabled", PS'(seen_en), PS'(nb));

    case (mode)
      1: begin
        repeat ($urandom_range(0, 3)) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
      end
      2: begin
        j = 1;
        while (!timeout_err && j < TO + 8) begin
          tick();
          j++;
        end
        check("wdog_cycles", PS'(j), PS'(TO));
        m_err = 1'b1;
      end
      3: begin
        repeat (3) tick();
        #2 reset_n = 1'b0;
        #1;
        check("rst_mod_enable", PS'(mod_enable), PS'(0));
        check("rst_busy", PS'(busy), PS'(0));
        check("rst_grant", PS'(grant), PS'(0));
        check("rst_ser_load", PS'(ser_load), PS'(0));
        check("rst_timeout_err", PS'(timeout_err), PS'(0));
        check("rst_packets_sent", PS'(packets_sent), PS'(0));
        check("rst_packet_out", packet_out, PS'(0));
        check("rst_active_id", PS'(active_id), PS'(0));
        tick();
        reset_n = 1'b1;
        model_reset();
        return;
      end
      default: m_sent++;
    endcase

    check("mod_en_stop", PS'(mod_enable), PS'(0));
    j = 0;
    while (busy && j < 64) begin
      j++;
      tick();
    end
    check("gap_len", PS'(j), PS'(gap_eff));
    check("packets_sent", PS'(packets_sent), PS'(m_sent));
    check("timeout_err", PS'(timeout_err), PS'(m_err));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    int mode;
    gap_eff   = GAP_A;
    hold_mode = 0;
    model_reset();
    do_reset();

    check("reset_grant", PS'(grant), PS'(0));
    check("reset_busy", PS'(busy), PS'(0));
    check("reset_mod_enable", PS'(mod_enable), PS'(0));
    check("reset_ser_load", PS'(ser_load), PS'(0));
    check("reset_packets_sent", PS'(packets_sent), PS'(0));
    check("reset_timeout_err", PS'(timeout_err), PS'(0));
    check("reset_packet_out", packet_out, PS'(0));
    check("reset_active_id", PS'(active_id), PS'(0));

    // single source, one strobe every 8 cycles
    req_packet[0 +: PS] = 192'hff54_68a1_93c7_0b2e_5d4f_8e16_c3a9_7f02_4b8d_e610_2c97_6521;
    req = 4'b0001;
    serve(0, 0, 7, 7);

    // all sources held high: strict rotation from source 0
    do_reset();
    hold_mode = 2;
    for (int i = 0; i < NR; i++) req_packet[i*PS +: PS] = rand_pkt();
    req = 4'b1111;
    repeat (5) serve(0, 0, 0, 2);
    check("five_packets", PS'(packets_sent), PS'(5));

    // abort after 50 bits, then the next pending source
    serve(1, 50, 0, 2);
    serve(0, 0, 0, 2);

    // watchdog: stall after 30 bits
    serve(2, 30, 0, 2);

    // random traffic mixing completions, aborts and coincident abort/final bit
    hold_mode = 1;
    req = '0;
    repeat (12) begin
      ensure_req();
      mode = ($urandom_range(0, 3) == 0) ? 1 : (($urandom_range(0, 4) == 0) ? 4 : 0);
      serve(mode, $urandom_range(1, PS - 1), 0, 3);
    end

    // reset during SEND at bit 100, then req=0110 must grant source 1 first
    ensure_req();
    serve(3, 100, 0, 2);
    hold_mode = 0;
    req_packet[1*PS +: PS] = rand_pkt();
    req_packet[2*PS +: PS] = rand_pkt();
    req = 4'b0110;
    serve(0, 0, 0, 2);
    serve(0, 0, 0, 2);

    // GAP_CYCLES = 0 instance: final strobe with abort, one gap cycle, re-arbitrate
    do_reset();
    sel = 1'b1;
    gap_eff = 1;
    req_packet[0 +: PS]  = rand_pkt();
    req_packet[PS +: PS] = rand_pkt();
    req = 4'b0011;
    serve(4, 0, 0, 2);
    serve(0, 0, 0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
